// File: rtl/ocp_nic_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module   : ocp_nic_pwr_seq
// Brief    : Power sequencer for one OCP NIC 3.0 slot. Brings up the aux rail,
//            then the main rail, then releases PERST#. Powers down in reverse
//            order with fixed gaps, and latches a fault on any rail failure.
//            A single 16-bit step counter times every delay and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ocp_nic_pwr_seq #(
    parameter logic [15:0] PG_TIMEOUT = 16'd1000,
    parameter logic [15:0] DN_DLY     = 16'd10
) (
    input  logic        clk_in,
    input  logic        iRst,
    input  logic        iNic_prsnt_n,
    input  logic        iPwr_on_req,
    input  logic        iAux_pg,
    input  logic        iMain_pg,
    input  logic [15:0] iAux2main_dly,
    input  logic [15:0] iMain2perst_dly,
    output logic        oAux_en,
    output logic        oMain_en,
    output logic        oPerst_n,
    output logic        oFault,
    output logic [3:0]  oSeq_state
);

    // ------------------------------------------------------------------------
    // State encodings (visible on oSeq_state for BMC readout)
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_AUX_ON   = 4'd1;
    localparam logic [3:0] c_AUX_DLY  = 4'd2;
    localparam logic [3:0] c_MAIN_ON  = 4'd3;
    localparam logic [3:0] c_MAIN_DLY = 4'd4;
    localparam logic [3:0] c_RUN      = 4'd5;
    localparam logic [3:0] c_DN_MAIN  = 4'd6;
    localparam logic [3:0] c_DN_AUX   = 4'd7;
    localparam logic [3:0] c_FAULT    = 4'd8;

    // A delay of D holds a state for max(D,1) cycles, so the exit compare
    // value is max(D,1)-1. A zero timeout behaves like a timeout of one.
    localparam logic [15:0] c_PG_LIM = (PG_TIMEOUT == 16'd0) ? 16'd0 : (PG_TIMEOUT - 16'd1);
    localparam logic [15:0] c_DN_LIM = (DN_DLY == 16'd0) ? 16'd0 : (DN_DLY - 16'd1);
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [3:0]  r_state;
    logic [15:0] r_cnt;
    logic        r_aux_en;
    logic        r_main_en;
    logic        r_perst_n;
    logic        r_fault;

    logic [3:0]  w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_aux_en_nxt;
    logic        w_main_en_nxt;
    logic        w_perst_n_nxt;
    logic        w_fault_nxt;
    logic [15:0] w_a2m_lim;
    logic [15:0] w_m2p_lim;
    logic        w_abort;
    logic        w_pg_tmo;
    logic        w_dn_done;

    // Delay limits track the inputs every cycle; ">=" makes a value lowered
    // mid-delay below the current count exit on the very next edge.
    always_comb begin
        w_a2m_lim = (iAux2main_dly == 16'd0) ? 16'd0 : (iAux2main_dly - 16'd1);
        w_m2p_lim = (iMain2perst_dly == 16'd0) ? 16'd0 : (iMain2perst_dly - 16'd1);
        w_abort   = (~iPwr_on_req) | iNic_prsnt_n;
        w_pg_tmo  = (r_cnt >= c_PG_LIM);
        w_dn_done = (r_cnt >= c_DN_LIM);
    end

    // Next-state selection; rail faults outrank aborts, pg outranks timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (!iNic_prsnt_n && iPwr_on_req) begin
                    w_state_nxt = c_AUX_ON;
                end
            end
            c_AUX_ON: begin
                if (w_abort) begin
                    w_state_nxt = c_DN_AUX;
                end else if (iAux_pg) begin
                    w_state_nxt = c_AUX_DLY;
                end else if (w_pg_tmo) begin
                    w_state_nxt = c_FAULT;
                end
            end
            c_AUX_DLY: begin
                if (!iAux_pg) begin
                    w_state_nxt = c_FAULT;
                end else if (w_abort) begin
                    w_state_nxt = c_DN_AUX;
                end else if (r_cnt >= w_a2m_lim) begin
                    w_state_nxt = c_MAIN_ON;
                end
            end
            c_MAIN_ON: begin
                if (!iAux_pg) begin
                    w_state_nxt = c_FAULT;
                end else if (w_abort) begin
                    w_state_nxt = c_DN_MAIN;
                end else if (iMain_pg) begin
                    w_state_nxt = c_MAIN_DLY;
                end else if (w_pg_tmo) begin
                    w_state_nxt = c_FAULT;
                end
            end
            c_MAIN_DLY: begin
                if (!iAux_pg || !iMain_pg) begin
                    w_state_nxt = c_FAULT;
                end else if (w_abort) begin
                    w_state_nxt = c_DN_MAIN;
                end else if (r_cnt >= w_m2p_lim) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (!iAux_pg || !iMain_pg) begin
                    w_state_nxt = c_FAULT;
                end else if (w_abort) begin
                    w_state_nxt = c_DN_MAIN;
                end
            end
            // Power-down ignores pg and new requests until IDLE is reached.
            c_DN_MAIN: begin
                if (w_dn_done) begin
                    w_state_nxt = c_DN_AUX;
                end
            end
            c_DN_AUX: begin
                if (w_dn_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_FAULT: begin
                if (!iPwr_on_req) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Step counter: restarts on every state change, saturates instead of wrapping.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = 16'd0;
        end else if (r_cnt != c_CNT_MAX) begin
            w_cnt_nxt = r_cnt + 16'd1;
        end
    end

    // Output decode from the next state so the registered outputs change on
    // the same edge as the state. Main stays on through DN_MAIN and aux
    // through DN_AUX, giving the DN_DLY gaps between PERST#, main-off and
    // aux-off; FAULT drops everything at once.
    always_comb begin
        w_aux_en_nxt  = 1'b0;
        w_main_en_nxt = 1'b0;
        w_perst_n_nxt = 1'b0;
        w_fault_nxt   = 1'b0;
        case (w_state_nxt)
            c_AUX_ON, c_AUX_DLY, c_DN_AUX: begin
                w_aux_en_nxt = 1'b1;
            end
            c_MAIN_ON, c_MAIN_DLY, c_DN_MAIN: begin
                w_aux_en_nxt  = 1'b1;
                w_main_en_nxt = 1'b1;
            end
            c_RUN: begin
                w_aux_en_nxt  = 1'b1;
                w_main_en_nxt = 1'b1;
                w_perst_n_nxt = 1'b1;
            end
            c_FAULT: begin
                w_fault_nxt = 1'b1;
            end
            default: begin
                w_aux_en_nxt = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset drops every rail at once.
    always_ff @(posedge clk_in or posedge iRst) begin
        if (iRst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 16'd0;
            r_aux_en  <= 1'b0;
            r_main_en <= 1'b0;
            r_perst_n <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_aux_en  <= w_aux_en_nxt;
            r_main_en <= w_main_en_nxt;
            r_perst_n <= w_perst_n_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

    assign oAux_en    = r_aux_en;
    assign oMain_en   = r_main_en;
    assign oPerst_n   = r_perst_n;
    assign oFault     = r_fault;
    assign oSeq_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ocp_nic_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ocp_nic_pwr_seq
// Brief    : Self-checking bench for ocp_nic_pwr_seq. Table of input segments,
//            each held for a number of edges, with the expected outputs pushed
//            to a scoreboard and compared after the last edge of the segment.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ocp_nic_pwr_seq;

    logic        clk;
    logic        rst;
    logic        nic_prsnt_n;
    logic        pwr_on_req;
    logic        aux_pg;
    logic        main_pg;
    logic [15:0] a2m_dly;
    logic [15:0] m2p_dly;
    logic        aux_en;
    logic        main_en;
    logic        perst_n;
    logic        fault;
    logic [3:0]  seq_state;

    ocp_nic_pwr_seq #(
        .PG_TIMEOUT (16'd16),
        .DN_DLY     (16'd10)
    ) u_dut (
        .clk_in          (clk),
        .iRst            (rst),
        .iNic_prsnt_n    (nic_prsnt_n),
        .iPwr_on_req     (pwr_on_req),
        .iAux_pg         (aux_pg),
        .iMain_pg        (main_pg),
        .iAux2main_dly   (a2m_dly),
        .iMain2perst_dly (m2p_dly),
        .oAux_en         (aux_en),
        .oMain_en        (main_en),
        .oPerst_n        (perst_n),
        .oFault          (fault),
        .oSeq_state      (seq_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output word: {aux_en, main_en, perst_n, fault, state[3:0]}
    typedef struct {
        logic        req;
        logic        prsnt_n;
        logic        apg;
        logic        mpg;
        logic [15:0] a2m;
        logic [15:0] m2p;
        int          ncyc;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] exp;
    } sb_t;

    vec_t tv[$];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [7:0] ex(input logic a, input logic m, input logic p,
                                      input logic f, input logic [3:0] st);
        return {a, m, p, f, st};
    endfunction

    task automatic add_v(input logic r, input logic pn, input logic ap, input logic mp,
                         input logic [15:0] a, input logic [15:0] m, input int n,
                         input logic [7:0] e);
        vec_t v;
        v.req = r; v.prsnt_n = pn; v.apg = ap; v.mpg = mp;
        v.a2m = a; v.m2p = m; v.ncyc = n; v.exp = e;
        tv.push_back(v);
    endtask

    task automatic push_exp(input int id, input logic [7:0] e);
        sb_t s;
        s.id  = id;
        s.exp = e;
        sb.push_back(s);
    endtask

    task automatic pop_check();
        sb_t        s;
        logic [7:0] act;
        act = {aux_en, main_en, perst_n, fault, seq_state};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual %h", act);
        end else begin
            s = sb.pop_front();
            if (act !== s.exp) begin
                errors++;
                $display("FAIL vec%0d actual aux/main/perst/fault/state=%b_%h required %b_%h",
                         s.id, act[7:4], act[3:0], s.exp[7:4], s.exp[3:0]);
            end
        end
    endtask

    initial begin
        // Nominal up/down: delays 5/8, pg returned 3 cycles after each enable
        add_v(1,0,0,0,5,8, 1, ex(1,0,0,0,1));
        add_v(1,0,0,0,5,8, 2, ex(1,0,0,0,1));
        add_v(1,0,1,0,5,8, 1, ex(1,0,0,0,2));
        add_v(1,0,1,0,5,8, 4, ex(1,0,0,0,2));
        add_v(1,0,1,0,5,8, 1, ex(1,1,0,0,3));
        add_v(1,0,1,0,5,8, 2, ex(1,1,0,0,3));
        add_v(1,0,1,1,5,8, 1, ex(1,1,0,0,4));
        add_v(1,0,1,1,5,8, 7, ex(1,1,0,0,4));
        add_v(1,0,1,1,5,8, 1, ex(1,1,1,0,5));
        add_v(0,0,1,1,5,8, 1, ex(1,1,0,0,6));
        add_v(0,0,1,1,5,8, 9, ex(1,1,0,0,6));
        add_v(0,0,1,1,5,8, 1, ex(1,0,0,0,7));
        add_v(0,0,1,1,5,8, 9, ex(1,0,0,0,7));
        add_v(0,0,1,1,5,8, 1, ex(0,0,0,0,0));
        // Aux timeout (16 cycles), sticky fault until request drops
        add_v(1,0,0,0,5,8, 1, ex(1,0,0,0,1));
        add_v(1,0,0,0,5,8,15, ex(1,0,0,0,1));
        add_v(1,0,0,0,5,8, 1, ex(0,0,0,1,8));
        add_v(1,0,0,0,5,8, 3, ex(0,0,0,1,8));
        add_v(0,0,0,0,5,8, 1, ex(0,0,0,0,0));
        // Zero delays, pg on the timeout cycle wins, then RUN main-pg fault
        add_v(1,0,0,0,0,0, 1, ex(1,0,0,0,1));
        add_v(1,0,0,0,0,0,15, ex(1,0,0,0,1));
        add_v(1,0,1,0,0,0, 1, ex(1,0,0,0,2));
        add_v(1,0,1,0,0,0, 1, ex(1,1,0,0,3));
        add_v(1,0,1,1,0,0, 1, ex(1,1,0,0,4));
        add_v(1,0,1,1,0,0, 1, ex(1,1,1,0,5));
        add_v(1,0,1,0,0,0, 1, ex(0,0,0,1,8));
        add_v(0,0,0,0,0,0, 1, ex(0,0,0,0,0));
        // Presence lost in AUX_DLY; request held through DN_AUX, restart after IDLE
        add_v(1,0,0,0,5,8, 1, ex(1,0,0,0,1));
        add_v(1,0,1,0,5,8, 1, ex(1,0,0,0,2));
        add_v(1,1,1,0,5,8, 1, ex(1,0,0,0,7));
        add_v(1,0,1,0,5,8, 9, ex(1,0,0,0,7));
        add_v(1,0,1,0,5,8, 1, ex(0,0,0,0,0));
        add_v(1,0,1,0,5,8, 1, ex(1,0,0,0,1));
        // Up to RUN with delays 0/3 ahead of the mid-RUN reset
        add_v(1,0,1,0,0,3, 1, ex(1,0,0,0,2));
        add_v(1,0,1,0,0,3, 1, ex(1,1,0,0,3));
        add_v(1,0,1,1,0,3, 1, ex(1,1,0,0,4));
        add_v(1,0,1,1,0,3, 2, ex(1,1,0,0,4));
        add_v(1,0,1,1,0,3, 1, ex(1,1,1,0,5));

        rst         = 1'b1;
        nic_prsnt_n = 1'b1;
        pwr_on_req  = 1'b0;
        aux_pg      = 1'b0;
        main_pg     = 1'b0;
        a2m_dly     = 16'd0;
        m2p_dly     = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        push_exp(-1, ex(0,0,0,0,0));
        pop_check();
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            pwr_on_req  = tv[i].req;
            nic_prsnt_n = tv[i].prsnt_n;
            aux_pg      = tv[i].apg;
            main_pg     = tv[i].mpg;
            a2m_dly     = tv[i].a2m;
            m2p_dly     = tv[i].m2p;
            push_exp(i, tv[i].exp);
            repeat (tv[i].ncyc) @(posedge clk);
            #1;
            pop_check();
        end

        // Asynchronous reset mid-RUN: outputs drop with no clock edge
        #2;
        rst = 1'b1;
        #1;
        push_exp(100, ex(0,0,0,0,0));
        pop_check();
        #1;
        rst = 1'b0;
        push_exp(101, ex(0,0,0,0,0));
        pop_check();
        // Request still high and card present: restart from IDLE
        @(posedge clk);
        #1;
        push_exp(102, ex(1,0,0,0,1));
        pop_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
